// File: rtl/latch_fifo.sv
// latch_fifo: parametrised first-word-fall-through FIFO with valid/ready
// handshakes on both sides, occupancy flags and a synchronous flush.
// Status flags are registered from the next-state count, so they never
// depend combinationally on IN_VALID or OUT_READY.
module latch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CW-1:0]    COUNT,
    output logic             FULL,
    output logic             EMPTY
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic             w_clear;
    logic [CW-1:0]    w_count_nxt;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        logic [AW-1:0] n;
        if (p == AW'(DEPTH - 1)) begin
            n = {AW{1'b0}};
        end else begin
            n = p + AW'(1);
        end
        return n;
    endfunction

    // Handshake qualification: only registered flags gate transfers.
    always_comb begin
        w_push  = IN_VALID  && !r_full;
        w_pop   = OUT_READY && !r_empty;
        w_clear = RST || FLUSH;
    end

    // Next occupancy: push-only increments, pop-only decrements.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Control state: pointers, count and flags; RST/FLUSH empty the FIFO.
    always_ff @(posedge CLK) begin
        if (w_clear) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == {CW{1'b0}});
        end
    end

    // Storage write; contents are not cleared by RST or FLUSH.
    always_ff @(posedge CLK) begin
        if (w_push && !w_clear) begin
            r_mem[r_wptr] <= IN_DATA;
        end
    end

    // Output decode: head word falls through, status from registered flags.
    always_comb begin
        OUT_DATA  = r_mem[r_rptr];
        OUT_VALID = !r_empty;
        IN_READY  = !r_full;
        COUNT     = r_count;
        FULL      = r_full;
        EMPTY     = r_empty;
    end

endmodule

// File: tb/tb_latch_fifo.sv
// Self-checking bench for latch_fifo: three instances (DEPTH 4, 3, 5,
// WIDTH 8) checked every cycle against a queue-based reference model,
// plus directed checks for fill/drain, wrap, edge push+pop, flush and
// reset during a random stream.
module tb_latch_fifo;

    logic       CLK = 1'b0;
    logic [2:0] rst       = 3'b000;
    logic [2:0] flush     = 3'b000;
    logic [2:0] in_valid  = 3'b000;
    logic [2:0] out_ready = 3'b000;
    logic [7:0] in_data [3];

    logic [2:0] in_ready;
    logic [2:0] out_valid;
    logic [2:0] full;
    logic [2:0] empty;
    logic [7:0] od0, od1, od2;
    logic [2:0] cn0, cn2;
    logic [1:0] cn1;

    int dep [3] = '{4, 3, 5};
    logic [7:0] q [3][$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    latch_fifo #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .CLK(CLK), .RST(rst[0]), .FLUSH(flush[0]), .IN_DATA(in_data[0]),
        .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]), .OUT_DATA(od0),
        .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .COUNT(cn0),
        .FULL(full[0]), .EMPTY(empty[0])
    );

    latch_fifo #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .CLK(CLK), .RST(rst[1]), .FLUSH(flush[1]), .IN_DATA(in_data[1]),
        .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]), .OUT_DATA(od1),
        .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .COUNT(cn1),
        .FULL(full[1]), .EMPTY(empty[1])
    );

    latch_fifo #(.WIDTH(8), .DEPTH(5)) u_d5 (
        .CLK(CLK), .RST(rst[2]), .FLUSH(flush[2]), .IN_DATA(in_data[2]),
        .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]), .OUT_DATA(od2),
        .OUT_VALID(out_valid[2]), .OUT_READY(out_ready[2]), .COUNT(cn2),
        .FULL(full[2]), .EMPTY(empty[2])
    );

    function automatic logic [7:0] get_od(input int i);
        logic [7:0] v;
        case (i)
            0:       v = od0;
            1:       v = od1;
            default: v = od2;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] get_cnt(input int i);
        logic [2:0] v;
        case (i)
            0:       v = cn0;
            1:       v = {1'b0, cn1};
            default: v = cn2;
        endcase
        return v;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every instance against its reference queue.
    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int sz;
            sz = q[i].size();
            check_val($sformatf("count%0d", i), 32'(get_cnt(i)), 32'(sz));
            check_val($sformatf("empty%0d", i), 32'(empty[i]), 32'(sz == 0));
            check_val($sformatf("full%0d", i), 32'(full[i]), 32'(sz == dep[i]));
            check_val($sformatf("in_ready%0d", i), 32'(in_ready[i]), 32'(sz != dep[i]));
            check_val($sformatf("out_valid%0d", i), 32'(out_valid[i]), 32'(sz != 0));
            if (sz > 0) begin
                check_val($sformatf("out_data%0d", i), 32'(get_od(i)), 32'(q[i][0]));
            end
        end
    endtask

    // One clock: model decisions from pre-edge inputs, then edge, then check.
    task automatic cyc();
        bit [2:0]   do_clr, do_pop, do_push;
        logic [7:0] pd [3];
        for (int i = 0; i < 3; i++) begin
            do_clr[i]  = rst[i] | flush[i];
            do_pop[i]  = out_ready[i] && (q[i].size() > 0);
            do_push[i] = in_valid[i] && (q[i].size() < dep[i]);
            pd[i]      = in_data[i];
        end
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            if (do_clr[i]) begin
                q[i].delete();
            end else begin
                if (do_pop[i]) void'(q[i].pop_front());
                if (do_push[i]) q[i].push_back(pd[i]);
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] fill_vals [4];
        fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 3; i++) in_data[i] = 8'h00;

        // Reset for two cycles.
        rst = 3'b111;
        cyc();
        cyc();
        rst = 3'b000;
        check_val("rst_count", 32'(cn0), 32'd0);
        check_val("rst_empty", 32'(empty[0]), 32'd1);
        check_val("rst_in_ready", 32'(in_ready[0]), 32'd1);

        // Fill DEPTH=4.
        for (int k = 0; k < 4; k++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = fill_vals[k];
            cyc();
            check_val("fill_count", 32'(cn0), 32'(k + 1));
        end
        check_val("fill_full", 32'(full[0]), 32'd1);
        check_val("fill_in_ready", 32'(in_ready[0]), 32'd0);
        in_data[0] = 8'h55;
        cyc();
        check_val("overflow_count", 32'(cn0), 32'd4);
        in_valid[0] = 1'b0;

        // Drain in order.
        out_ready[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_val("drain_data", 32'(od0), 32'(fill_vals[k]));
            cyc();
        end
        check_val("drain_empty", 32'(empty[0]), 32'd1);
        check_val("drain_out_valid", 32'(out_valid[0]), 32'd0);
        // Underflow attempt is ignored.
        cyc();
        check_val("underflow_count", 32'(cn0), 32'd0);
        out_ready[0] = 1'b0;

        // Push+pop at FULL: pop happens, push dropped.
        in_valid[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data[0] = 8'hC0 + 8'(k);
            cyc();
        end
        in_data[0]   = 8'hEE;
        out_ready[0] = 1'b1;
        cyc();
        check_val("full_pp_count", 32'(cn0), 32'd3);
        in_valid[0] = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check_val("full_pp_data", 32'(od0), 32'(8'hC0 + 8'(k)));
            cyc();
        end
        // Push+pop at EMPTY: push accepted, no pop.
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hA5;
        cyc();
        check_val("empty_pp_count", 32'(cn0), 32'd1);
        check_val("empty_pp_data", 32'(od0), 32'hA5);
        in_valid[0]  = 1'b0;
        cyc();
        out_ready[0] = 1'b0;

        // Flush with COUNT=3 and concurrent push+pop.
        in_valid[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data[0] = 8'h60 + 8'(k);
            cyc();
        end
        check_val("pre_flush_count", 32'(cn0), 32'd3);
        in_data[0]   = 8'h99;
        out_ready[0] = 1'b1;
        flush[0]     = 1'b1;
        cyc();
        flush[0]     = 1'b0;
        out_ready[0] = 1'b0;
        check_val("flush_count", 32'(cn0), 32'd0);
        check_val("flush_empty", 32'(empty[0]), 32'd1);
        in_data[0] = 8'hAB;
        cyc();
        in_valid[0] = 1'b0;
        check_val("post_flush_data", 32'(od0), 32'hAB);
        out_ready[0] = 1'b1;
        cyc();
        out_ready[0] = 1'b0;

        // Wrap-around with DEPTH=3 at COUNT=1.
        in_valid[1] = 1'b1;
        in_data[1]  = 8'h00;
        cyc();
        out_ready[1] = 1'b1;
        for (int k = 1; k < 10; k++) begin
            in_data[1] = 8'(k);
            check_val("wrap_data", 32'(od1), 32'(k - 1));
            cyc();
            check_val("wrap_count", 32'(cn1), 32'd1);
        end
        in_valid[1] = 1'b0;
        check_val("wrap_last", 32'(od1), 32'h09);
        cyc();
        check_val("wrap_empty", 32'(empty[1]), 32'd1);
        out_ready[1] = 1'b0;

        // Random stream on DEPTH=5 with reset+flush mid-stream.
        for (int c = 0; c < 400; c++) begin
            in_valid[2]  = 1'($urandom_range(0, 1));
            out_ready[2] = 1'($urandom_range(0, 1));
            in_data[2]   = 8'($urandom);
            flush[2]     = ($urandom_range(0, 39) == 0);
            rst[2]       = (c == 200);
            if (c == 200) flush[2] = 1'b1;
            cyc();
            if (c == 200) begin
                check_val("midrst_count", 32'(cn2), 32'd0);
                check_val("midrst_empty", 32'(empty[2]), 32'd1);
            end
        end
        rst[2] = 1'b0;
        flush[2] = 1'b0;
        in_valid[2] = 1'b0;
        out_ready[2] = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
